period_sched: RTL and testbench

PERIOD_SCHED -- requirements
Module: period_sched

---
 rtl/sched_pkg.sv | 19 +
 rtl/tick_gen.sv | 37 +++
 rtl/period_sched.sv | 124 ++++++++++++
 tb/tb_period_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types and constants for the period scheduler: FSM state encoding,
// period width and the request clamp helper.
package sched_pkg;

  localparam int PERIOD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    HOLD = 2'd3
  } state_t;

  function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] val,
                                                       input logic [PERIOD_W-1:0] min_val);
    return (val < min_val) ? min_val : val;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Interval counter for the period scheduler: counts enabled cycles and emits a
// registered one-cycle tick every 'period' enabled cycles; clear wins over enable.
module tick_gen
  import sched_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic [PERIOD_W-1:0] period,
  output logic                wrap,
  output logic                tick
);

  localparam logic [PERIOD_W-1:0] ONE = 1;

  logic [PERIOD_W-1:0] count;

  // wrap is the combinational "this edge ends the interval" flag; >= guards a
  // period shortened below the frozen count while held.
  assign wrap = en && !clr && (count >= period - ONE);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= wrap;
      if (clr || wrap) begin
        count <= '0;
      end else if (en) begin
        count <= count + ONE;
      end
    end
  end

endmodule

// File: rtl/period_sched.sv
// Programmable periodic tick scheduler with start/stop/pause control and a
// valid/ready period-update port. Define PERIOD_SCHED_RAMP_EN for period ramping.
module period_sched
  import sched_pkg::*;
#(
  parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = 32'd50_000_000,
  parameter logic [PERIOD_W-1:0] MIN_PERIOD     = 32'd2,
  parameter logic [PERIOD_W-1:0] RAMP_STEP      = 32'd1_000_000,
  parameter logic [15:0]         RAMP_TICKS     = 16'd8
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic                req_valid,
  input  logic [PERIOD_W-1:0] req_period,
  output logic                req_ready,
  output logic                tick,
  output logic [PERIOD_W-1:0] cur_period,
  output logic [1:0]          state_o,
  output logic                err
);

  state_t              state, state_next;
  logic                cnt_en;
  logic                wrap;
  logic                accept;
  logic                req_low;
  logic                pend_load;
  logic [PERIOD_W-1:0] req_clamped;
  logic [PERIOD_W-1:0] pend_period;

  assign accept      = req_valid && req_ready;
  assign req_low     = req_period < MIN_PERIOD;
  assign req_clamped = clamp_period(req_period, MIN_PERIOD);
  assign pend_load   = wrap && (state == PEND);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (start) state_next = RUN;
        RUN: begin
          if (accept)     state_next = PEND;
          else if (pause) state_next = HOLD;
        end
        PEND: if (wrap) state_next = pause ? HOLD : RUN;
        HOLD: if (!pause) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // HOLD counts on its exit edge so a pause of N cycles delays the tick by exactly N.
  always_comb begin
    req_ready = (state != PEND);
    state_o   = state;
    cnt_en    = (((state == RUN) || (state == HOLD)) && !pause) || (state == PEND);
  end

  tick_gen u_tick_gen (
    .clk_in (clk_in),
    .rst    (rst),
    .en     (cnt_en),
    .clr    (stop),
    .period (cur_period),
    .wrap   (wrap),
    .tick   (tick)
  );

`ifdef PERIOD_SCHED_RAMP_EN
  logic [15:0]         ramp_cnt;
  logic                ramp_hit;
  logic [PERIOD_W-1:0] ramp_period;

  assign ramp_hit    = wrap && ((ramp_cnt + 16'd1) >= RAMP_TICKS);
  assign ramp_period = (cur_period < MIN_PERIOD + RAMP_STEP) ? MIN_PERIOD
                                                             : cur_period - RAMP_STEP;

  // A buffered update landing on a ramp tick restarts the ramp count.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      ramp_cnt <= '0;
    end else if (wrap) begin
      ramp_cnt <= (pend_load || ramp_hit) ? 16'd0 : ramp_cnt + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cur_period  <= DEFAULT_PERIOD;
      pend_period <= '0;
      err         <= 1'b0;
    end else begin
      err <= accept && req_low;
      if (accept && (state == RUN)) begin
        pend_period <= req_clamped;
      end
      if (pend_load) begin
        cur_period <= pend_period;
      end else if (accept && ((state == IDLE) || (state == HOLD))) begin
        cur_period <= req_clamped;
      end
`ifdef PERIOD_SCHED_RAMP_EN
      else if (ramp_hit) begin
        cur_period <= ramp_period;
      end
`endif
    end
  end

endmodule

// File: tb/tb_period_sched.sv
// Directed-vector bench for period_sched; ramp checks run only when
// PERIOD_SCHED_RAMP_EN is defined.
module tb_period_sched;
  import sched_pkg::*;

  typedef struct {
    logic        start;
    logic        stop;
    logic        pause;
    logic        req_valid;
    logic [31:0] req_period;
    logic        exp_tick;
    logic        exp_ready;
    logic [1:0]  exp_state;
    logic [31:0] exp_period;
    logic        exp_err;
  } vec_t;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        start, stop, pause, req_valid;
  logic [31:0] req_period;
  logic        req_ready, tick, err;
  logic [31:0] cur_period;
  logic [1:0]  state_o;

  int   nVectors = 0;
  int   nMiscompares = 0;
  vec_t vecs[$];

  always #5 clk_in = ~clk_in;

  period_sched #(
    .DEFAULT_PERIOD (32'd4),
    .MIN_PERIOD     (32'd2),
    .RAMP_STEP      (32'd1),
    .RAMP_TICKS     (16'hFFFF)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .req_valid  (req_valid),
    .req_period (req_period),
    .req_ready  (req_ready),
    .tick       (tick),
    .cur_period (cur_period),
    .state_o    (state_o),
    .err        (err)
  );

`ifdef PERIOD_SCHED_RAMP_EN
  logic        r_start;
  logic        r_ready, r_tick, r_err;
  logic [31:0] r_period;
  logic [1:0]  r_state;

  period_sched #(
    .DEFAULT_PERIOD (32'd20),
    .MIN_PERIOD     (32'd2),
    .RAMP_STEP      (32'd8),
    .RAMP_TICKS     (16'd2)
  ) dut_r (
    .clk_in     (clk_in),
    .rst        (rst),
    .start      (r_start),
    .stop       (1'b0),
    .pause      (1'b0),
    .req_valid  (1'b0),
    .req_period (32'd0),
    .req_ready  (r_ready),
    .tick       (r_tick),
    .cur_period (r_period),
    .state_o    (r_state),
    .err        (r_err)
  );
`endif

  function automatic vec_t mkv(input logic st, input logic sp, input logic pa, input logic rv,
                               input logic [31:0] rp, input logic tk, input logic rd,
                               input logic [1:0] s, input logic [31:0] cp, input logic er);
    vec_t v;
    v.start = st; v.stop = sp; v.pause = pa; v.req_valid = rv; v.req_period = rp;
    v.exp_tick = tk; v.exp_ready = rd; v.exp_state = s; v.exp_period = cp; v.exp_err = er;
    return v;
  endfunction

  task automatic checkVal(input string name, input int idx, input logic [31:0] act,
                          input logic [31:0] exp);
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s vec %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    nVectors++;
    checkVal("tick",       idx, {31'd0, tick},      {31'd0, v.exp_tick});
    checkVal("req_ready",  idx, {31'd0, req_ready}, {31'd0, v.exp_ready});
    checkVal("state_o",    idx, {30'd0, state_o},   {30'd0, v.exp_state});
    checkVal("cur_period", idx, cur_period,         v.exp_period);
    checkVal("err",        idx, {31'd0, err},       {31'd0, v.exp_err});
  endtask

  // Called at a falling edge: drive, cross one rising edge, return at the next falling edge.
  task automatic applyStimulus(input vec_t v);
    start      = v.start;
    stop       = v.stop;
    pause      = v.pause;
    req_valid  = v.req_valid;
    req_period = v.req_period;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic runVec(input vec_t v, input int idx);
    applyStimulus(v);
    checkOutput(v, idx);
  endtask

`ifdef PERIOD_SCHED_RAMP_EN
  task automatic waitTick(input int expInterval, input int idx);
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!r_tick && n < 100);
    nVectors++;
    checkVal("ramp_interval", idx, n, expInterval);
  endtask
`endif

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] s;
    start = 0; stop = 0; pause = 0; req_valid = 0; req_period = 0;
`ifdef PERIOD_SCHED_RAMP_EN
    r_start = 0;
`endif
    rst = 1'b1;
    #1;
    checkOutput(mkv(0, 0, 0, 0, 0, 0, 1, IDLE, 4, 0), -1);
    repeat (2) @(negedge clk_in);
    rst = 1'b0;

    // Free run at period 4: ticks at 4, 8, 12.
    vecs.push_back(mkv(1, 0, 0, 0, 0, 0, 1, RUN, 4, 0));
    for (int c = 1; c <= 12; c++)
      vecs.push_back(mkv(0, 0, 0, 0, 0, (c % 4 == 0), 1, RUN, 4, 0));

    // Update to 10 accepted at cycle 5, applied at the tick on cycle 8.
    vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 1, IDLE, 4, 0));
    vecs.push_back(mkv(1, 0, 0, 0, 0, 0, 1, RUN, 4, 0));
    for (int c = 1; c <= 28; c++) begin
      s = (c >= 5 && c <= 7) ? PEND : RUN;
      vecs.push_back(mkv(0, 0, 0, (c == 5), 32'd10,
                         (c == 4 || c == 8 || c == 18 || c == 28),
                         !(c >= 5 && c <= 7), s, (c >= 8) ? 32'd10 : 32'd4, 0));
    end

    // Pause for 5 cycles mid-interval: tick moves from 38 to 43.
    for (int c = 29; c <= 44; c++) begin
      s = (c >= 32 && c <= 36) ? HOLD : RUN;
      vecs.push_back(mkv(0, 0, (c >= 32 && c <= 36), 0, 0, (c == 43), 1, s, 10, 0));
    end

    // Start with stop: stop wins.
    vecs.push_back(mkv(1, 1, 0, 0, 0, 0, 1, IDLE, 10, 0));

    // Zero request in IDLE clamps to 2 with an err pulse, then ticks every 2.
    vecs.push_back(mkv(0, 0, 0, 1, 0, 0, 1, IDLE, 2, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1, IDLE, 2, 0));
    vecs.push_back(mkv(1, 0, 0, 0, 0, 0, 1, RUN, 2, 0));
    for (int c = 1; c <= 6; c++)
      vecs.push_back(mkv(0, 0, 0, 0, 0, (c % 2 == 0), 1, RUN, 2, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 1, IDLE, 2, 0));
    vecs.push_back(mkv(0, 0, 0, 1, 9, 0, 1, IDLE, 9, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1, IDLE, 9, 0));

    @(negedge clk_in);
    for (int i = 0; i < vecs.size(); i++)
      runVec(vecs[i], i);

    // Asynchronous reset while a buffered update is pending.
    runVec(mkv(1, 0, 0, 0, 0, 0, 1, RUN, 9, 0), 1000);
    runVec(mkv(0, 0, 0, 0, 0, 0, 1, RUN, 9, 0), 1001);
    runVec(mkv(0, 0, 0, 0, 0, 0, 1, RUN, 9, 0), 1002);
    runVec(mkv(0, 0, 0, 1, 7, 0, 0, PEND, 9, 0), 1003);
    req_valid = 0;
    #2 rst = 1'b1;
    #1 checkOutput(mkv(0, 0, 0, 0, 0, 0, 1, IDLE, 4, 0), 1004);
    @(negedge clk_in);
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      runVec(mkv(0, 0, 0, 0, 0, 0, 1, IDLE, 4, 0), 1005 + i);
    runVec(mkv(1, 0, 0, 0, 0, 0, 1, RUN, 4, 0), 1010);
    for (int c = 1; c <= 8; c++)
      runVec(mkv(0, 0, 0, 0, 0, (c % 4 == 0), 1, RUN, 4, 0), 1010 + c);

`ifdef PERIOD_SCHED_RAMP_EN
    begin
      int expIntervals[8] = '{20, 20, 12, 12, 4, 4, 2, 2};
      r_start = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      r_start = 1'b0;
      for (int k = 0; k < 8; k++)
        waitTick(expIntervals[k], 2000 + k);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
